pcie_tlp_rx_demux: RTL
======================

PCIE_TLP_RX_DEMUX -- requirements
Module: pcie_tlp_rx_demux

Interface
REQ-001 Parameter DATA_W, 256, width of all data buses.
REQ-002 Parameter EMPTY_W, 3, empty width in 32-bit DWs.
REQ-003 Parameter CNT_W, 32, statistics counter width.
REQ-004 clk  in  1  sole clock, all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous assert, active-low reset.
REQ-006 tlp_rx_st_data/empty/startofpacket/endofpacket/valid  in  DATA_W/EMPTY_W/1/1/1  inbound TLP stream; DW0 of the header is in data[31:0] on the SOP beat; empty is a count of unused DWs.
REQ-007 tlp_rx_st_ready  out  1  inbound backpressure.
REQ-008 req_st_data/empty/startofpacket/endofpacket/valid  out  DATA_W/EMPTY_W/1/1/1  memory/IO/config request stream.
REQ-009 req_st_ready  in  1  request-stream backpressure.
REQ-010 cpl_st_data/empty/startofpacket/endofpacket/valid  out  DATA_W/EMPTY_W/1/1/1  completion stream.
REQ-011 cpl_st_ready  in  1  completion-stream backpressure.
REQ-012 drop_count  out  CNT_W  count of TLPs discarded by class.
REQ-013 malformed_count  out  CNT_W  count of framing violations.

Function
REQ-014 The block SHALL decode the SOP-beat Type field, data[28:24], as follows: 00000, 00001, 00010, 00100 and 00101 -> REQ; 01010 and 01011 -> CPL; all other values -> DROP.
REQ-015 The FSM SHALL have the states IDLE, FWD_REQ, FWD_CPL and DROP; an accepted SOP beat without EOP SHALL move it to the decoded state; an accepted EOP beat SHALL return it to IDLE; a single-beat TLP (SOP and EOP together) SHALL leave it in IDLE.
REQ-016 Each output SHALL be a one-entry registered stage, so that an accepted beat appears on the selected output exactly 1 cycle after acceptance, with data, empty, SOP and EOP unmodified.
REQ-017 Beat acceptance SHALL occur when tlp_rx_st_valid and tlp_rx_st_ready are both high on the same cycle.
REQ-018 tlp_rx_st_ready SHALL be high when the destination register (the decoded class on a SOP beat in IDLE, otherwise the current state) is empty or being drained (its ready is high) in the same cycle.
REQ-019 tlp_rx_st_ready SHALL be constantly high when the destination is DROP; the combinational path from downstream ready to tlp_rx_st_ready is permitted.
REQ-020 An output's valid SHALL hold, with stable contents, until its ready is sampled high; a stall on one output SHALL NOT block a packet in progress on the other output once the FSM is in that state.
REQ-021 Simultaneous drain and load of one output register SHALL keep valid high and load the new beat.
REQ-022 drop_count SHALL increment by 1 per accepted SOP beat decoded as DROP.
REQ-023 A non-SOP beat accepted in IDLE SHALL be discarded and SHALL increment malformed_count.
REQ-024 A SOP beat accepted outside IDLE SHALL increment malformed_count and start a new packet per REQ-015; the prior packet SHALL be left unterminated downstream.
REQ-025 Both counters SHALL saturate at all-ones, not wrap.
REQ-026 Inbound valid low SHALL cause no state or counter change.

Reset
REQ-027 While reset_n is low: state=IDLE; both output valids=0; SOP/EOP/empty/data=0; both counters=0; tlp_rx_st_ready=0.
REQ-028 Reset assertion mid-packet SHALL discard all held beats with no EOP emitted; the first beat after release SHALL be treated per REQ-014/REQ-023.

Structure
REQ-029 A shared package pcie_tlp_pkg SHALL hold the TLP type-code constants, the class enum (REQ/CPL/DROP) and the FSM state typedef.
REQ-030 The output register SHALL be one sub-module, tlp_st_reg_stage, instantiated twice.

Verification
REQ-031 MRd 1-beat TLP (type 00000, SOP+EOP, empty=5), both readies high -> req_st valid 1 cycle later, empty=5; cpl_st_valid stays 0.
REQ-032 3-beat CplD (type 01010) with cpl_st_ready low for 4 cycles on beat 2 -> tlp_rx_st_ready low for those cycles; all 3 beats delivered in order; no beat is lost or duplicated.
REQ-033 Message TLP (type 10000, 2 beats) -> no output valid; drop_count=1; tlp_rx_st_ready high throughout.
REQ-034 Orphan non-SOP beat in IDLE, then SOP inside an MWr packet -> malformed_count=2; the second packet is forwarded on req_st.
REQ-035 Counters preloaded near max via 2^CNT_W drops (CNT_W=4 build) -> drop_count holds at 15.
REQ-036 reset_n asserted on beat 2 of a 4-beat MWr -> all valids 0 immediately; after release a new SOP is forwarded correctly.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
// Shared definitions for the PCIe TLP receive demultiplexer.
// Holds the header Type-field codes, the traffic class enum, the
// demux FSM state type and the Type-field decode helpers.
package pcie_tlp_pkg;

  // Bit position of the 5-bit Type field inside header DW0 (SOP beat).
  localparam int TYPE_LSB = 24;
  localparam int TYPE_MSB = 28;

  // Type codes routed to the request stream. Memory read/write share
  // a code; the Fmt field, not the Type field, tells them apart.
  localparam logic [4:0] TYPE_MEM    = 5'b00000;
  localparam logic [4:0] TYPE_MEM_LK = 5'b00001;
  localparam logic [4:0] TYPE_IO     = 5'b00010;
  localparam logic [4:0] TYPE_CFG0   = 5'b00100;
  localparam logic [4:0] TYPE_CFG1   = 5'b00101;

  // Type codes routed to the completion stream.
  localparam logic [4:0] TYPE_CPL    = 5'b01010;
  localparam logic [4:0] TYPE_CPL_LK = 5'b01011;

  typedef enum logic [1:0] {
    CLS_REQ  = 2'd0,
    CLS_CPL  = 2'd1,
    CLS_DROP = 2'd2
  } tlp_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FWD_REQ = 2'd1,
    ST_FWD_CPL = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;

  // Map a header Type field to its destination class.
  function automatic tlp_class_e decode_class(input logic [4:0] tlp_type);
    tlp_class_e cls;
    case (tlp_type)
      TYPE_MEM, TYPE_MEM_LK, TYPE_IO, TYPE_CFG0, TYPE_CFG1: cls = CLS_REQ;
      TYPE_CPL, TYPE_CPL_LK:                               cls = CLS_CPL;
      default:                                             cls = CLS_DROP;
    endcase
    return cls;
  endfunction

  // FSM state entered after a multi-beat SOP of the given class.
  function automatic rx_state_e class_to_state(input tlp_class_e cls);
    rx_state_e st;
    case (cls)
      CLS_REQ:  st = ST_FWD_REQ;
      CLS_CPL:  st = ST_FWD_CPL;
      default:  st = ST_DROP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/tlp_st_reg_stage.sv
// One-entry registered streaming stage (valid/ready with registered
// payload).
// Ports:
//   clk, reset_n      - clock, async active-low reset
//   load              - capture in_* this cycle (caller guarantees free)
//   in_data/empty/sop/eop - beat to capture
//   out_ready         - downstream ready
//   free              - register empty or draining this cycle
//   out_valid/data/empty/sop/eop - registered beat to downstream
module tlp_st_reg_stage
  import pcie_tlp_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic               out_ready,
  output logic               free,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_sop,
  output logic               out_eop
);

  logic               valid_r;
  logic [DATA_W-1:0]  data_r;
  logic [EMPTY_W-1:0] empty_r;
  logic               sop_r;
  logic               eop_r;

  // Holding register: load wins over drain so a same-cycle drain+load
  // keeps valid high with the new beat; payload only changes on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      empty_r <= '0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
      empty_r <= in_empty;
      sop_r   <= in_sop;
      eop_r   <= in_eop;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign free      = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_empty = empty_r;
  assign out_sop   = sop_r;
  assign out_eop   = eop_r;

endmodule

// File: rtl/pcie_tlp_rx_demux.sv
// PCIe TLP receive demultiplexer. Classifies each inbound TLP by the
// Type field of its SOP beat and steers the packet to the request
// stream, the completion stream, or discards it, counting discarded
// TLPs and framing violations.
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   tlp_rx_st_*                  - inbound TLP stream (ready is backpressure)
//   req_st_*                     - memory/IO/config request stream
//   cpl_st_*                     - completion stream
//   drop_count, malformed_count  - saturating statistics counters
module pcie_tlp_rx_demux
  import pcie_tlp_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  tlp_rx_st_data,
  input  logic [EMPTY_W-1:0] tlp_rx_st_empty,
  input  logic               tlp_rx_st_startofpacket,
  input  logic               tlp_rx_st_endofpacket,
  input  logic               tlp_rx_st_valid,
  output logic               tlp_rx_st_ready,
  output logic [DATA_W-1:0]  req_st_data,
  output logic [EMPTY_W-1:0] req_st_empty,
  output logic               req_st_startofpacket,
  output logic               req_st_endofpacket,
  output logic               req_st_valid,
  input  logic               req_st_ready,
  output logic [DATA_W-1:0]  cpl_st_data,
  output logic [EMPTY_W-1:0] cpl_st_empty,
  output logic               cpl_st_startofpacket,
  output logic               cpl_st_endofpacket,
  output logic               cpl_st_valid,
  input  logic               cpl_st_ready,
  output logic [CNT_W-1:0]   drop_count,
  output logic [CNT_W-1:0]   malformed_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rx_state_e        state_r;
  logic             run_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] malformed_cnt_r;

  tlp_class_e sop_class_s;
  tlp_class_e dest_s;
  logic       req_free_s;
  logic       cpl_free_s;
  logic       dest_free_s;
  logic       accept_s;
  logic       req_load_s;
  logic       cpl_load_s;
  logic       drop_hit_s;
  logic       malformed_hit_s;

  // Destination of the beat on the input this cycle. A SOP always goes
  // by its own decoded class (even mid-packet, where it restarts the
  // FSM); a continuation beat follows the packet in progress, and one
  // arriving in IDLE has no packet and is discarded.
  always_comb begin
    sop_class_s = decode_class(tlp_rx_st_data[TYPE_MSB:TYPE_LSB]);
    dest_s      = CLS_DROP;
    if (tlp_rx_st_startofpacket) begin
      dest_s = sop_class_s;
    end else begin
      case (state_r)
        ST_FWD_REQ: dest_s = CLS_REQ;
        ST_FWD_CPL: dest_s = CLS_CPL;
        default:    dest_s = CLS_DROP;
      endcase
    end
  end

  // Backpressure looks only at the destination register, so a stalled
  // output never blocks traffic bound for the other one. Discarded
  // beats are always accepted.
  always_comb begin
    dest_free_s = 1'b1;
    case (dest_s)
      CLS_REQ: dest_free_s = req_free_s;
      CLS_CPL: dest_free_s = cpl_free_s;
      default: dest_free_s = 1'b1;
    endcase
  end

  // run_r keeps ready low during reset and for the first edge after it.
  assign tlp_rx_st_ready = run_r & dest_free_s;
  assign accept_s        = tlp_rx_st_valid & tlp_rx_st_ready;
  assign req_load_s      = accept_s & (dest_s == CLS_REQ);
  assign cpl_load_s      = accept_s & (dest_s == CLS_CPL);
  assign drop_hit_s      = accept_s & tlp_rx_st_startofpacket & (sop_class_s == CLS_DROP);
  assign malformed_hit_s = accept_s &
                           ((tlp_rx_st_startofpacket  & (state_r != ST_IDLE)) |
                            (~tlp_rx_st_startofpacket & (state_r == ST_IDLE)));

  // Packet-tracking FSM; advances only on accepted beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (accept_s) begin
        if (tlp_rx_st_endofpacket) begin
          state_r <= ST_IDLE;
        end else if (tlp_rx_st_startofpacket) begin
          state_r <= class_to_state(sop_class_s);
        end else begin
          state_r <= state_r;
        end
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_r      <= '0;
      malformed_cnt_r <= '0;
    end else begin
      if (drop_hit_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
      if (malformed_hit_s && (malformed_cnt_r != CNT_MAX)) begin
        malformed_cnt_r <= malformed_cnt_r + CNT_ONE;
      end
    end
  end

  assign drop_count      = drop_cnt_r;
  assign malformed_count = malformed_cnt_r;

  tlp_st_reg_stage #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_req_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (req_load_s),
    .in_data   (tlp_rx_st_data),
    .in_empty  (tlp_rx_st_empty),
    .in_sop    (tlp_rx_st_startofpacket),
    .in_eop    (tlp_rx_st_endofpacket),
    .out_ready (req_st_ready),
    .free      (req_free_s),
    .out_valid (req_st_valid),
    .out_data  (req_st_data),
    .out_empty (req_st_empty),
    .out_sop   (req_st_startofpacket),
    .out_eop   (req_st_endofpacket)
  );

  tlp_st_reg_stage #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_cpl_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cpl_load_s),
    .in_data   (tlp_rx_st_data),
    .in_empty  (tlp_rx_st_empty),
    .in_sop    (tlp_rx_st_startofpacket),
    .in_eop    (tlp_rx_st_endofpacket),
    .out_ready (cpl_st_ready),
    .free      (cpl_free_s),
    .out_valid (cpl_st_valid),
    .out_data  (cpl_st_data),
    .out_empty (cpl_st_empty),
    .out_sop   (cpl_st_startofpacket),
    .out_eop   (cpl_st_endofpacket)
  );

endmodule
